// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding plus elaboration-time helpers for digit sizing and the saturation pattern.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ceil(bin_w * log10(2)) in fixed point; exact for every width up to 32
   function automatic int digits_needed(input int bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

   // Up to ten BCD nines; callers keep the low 4*DIGITS bits
   function automatic logic [39:0] all_nines(input int digits);
      logic [39:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         if (i < digits) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a display controller and the BCD converter.
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 13,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  neg;
   logic                  overflow;
   logic [DIGITS-1:0]     blank_mask;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, neg, overflow, blank_mask
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, neg, overflow, blank_mask
   );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit above 4, then shift left
// taking msb_in at the bottom; carry_out is the bit pushed out of the top digit.
module bcd_dabble_step #(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] digits_in,
   input  logic                msb_in,
   output logic [4*DIGITS-1:0] digits_out,
   output logic                carry_out
);

   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digits_in[4*i +: 4] > 4'd4)
            adj[4*i +: 4] = digits_in[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = digits_in[4*i +: 4];
      end
      {carry_out, digits_out} = {adj, msb_in};
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter with start/done handshake, optional signed input,
// saturation to all nines on overflow and leading-zero blanking for the display driver.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W       = 13,
   parameter int DIGITS      = 4,
   parameter int SIGNED_MODE = 0
) (
   input logic              clk,
   input logic              reset,
   bin2bcd_seq_if.slave     bus
);

   localparam int                  CNT_W     = $clog2(BIN_W + 1);
   localparam bit                  CAN_OVF   = (DIGITS < digits_needed(BIN_W));
   localparam logic [39:0]         NINES_ALL = all_nines(DIGITS);
   localparam logic [4*DIGITS-1:0] NINES     = NINES_ALL[4*DIGITS-1:0];
   localparam logic [DIGITS-1:0]   BLANK_RST = {DIGITS{1'b1}} << 1;

   state_t              state;
   logic [BIN_W-1:0]    mag;
   logic                sign;
   logic [4*DIGITS-1:0] scratch;
   logic                ovf_sticky;
   logic [CNT_W-1:0]    cnt;

   logic                accept;
   logic [BIN_W-1:0]    mag_in;
   logic [4*DIGITS-1:0] step_dig;
   logic                step_carry;
   logic [4*DIGITS-1:0] result;
   logic [DIGITS-1:0]   result_blank;
   logic                zero_run;

   // busy is low exactly when the FSM is outside SHIFT, so accept follows it
   assign accept = bus.start && (state != ST_SHIFT);

   // Two's-complement negate; the most negative value maps to 2^(BIN_W-1) unsigned
   always_comb begin
      if ((SIGNED_MODE != 0) && bus.bin_in[BIN_W-1])
         mag_in = ~bus.bin_in + BIN_W'(1);
      else
         mag_in = bus.bin_in;
   end

   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
      .digits_in  (scratch),
      .msb_in     (mag[BIN_W-1]),
      .digits_out (step_dig),
      .carry_out  (step_carry)
   );

   assign result = ovf_sticky ? NINES : scratch;

   always_comb begin
      zero_run     = 1'b1;
      result_blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run        = zero_run & (result[4*i +: 4] == 4'd0);
         result_blank[i] = zero_run;
      end
      result_blank[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         mag            <= '0;
         sign           <= 1'b0;
         scratch        <= '0;
         ovf_sticky     <= 1'b0;
         cnt            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.bcd_out    <= '0;
         bus.neg        <= 1'b0;
         bus.overflow   <= 1'b0;
         bus.blank_mask <= BLANK_RST;
      end else begin
         bus.done <= 1'b0;
         case (state)
            ST_SHIFT: begin
               scratch <= step_dig;
               mag     <= {mag[BIN_W-2:0], 1'b0};
               if (CAN_OVF && step_carry) ovf_sticky <= 1'b1;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state    <= ST_DONE;
                  bus.busy <= 1'b0;
               end
            end
            ST_DONE: begin
               bus.done       <= 1'b1;
               bus.bcd_out    <= result;
               bus.neg        <= sign;
               bus.overflow   <= ovf_sticky;
               bus.blank_mask <= result_blank;
               state          <= ST_IDLE;
            end
            default: ;
         endcase
         // A start in the DONE cycle overrides the return to IDLE for back-to-back use
         if (accept) begin
            state      <= ST_SHIFT;
            mag        <= mag_in;
            sign       <= (SIGNED_MODE != 0) && bus.bin_in[BIN_W-1];
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
            bus.busy   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: unsigned 13b/4 digits, signed 8b/3 digits, and 13b/3 digits.
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bin2bcd_seq_if #(.BIN_W(13), .DIGITS(4)) ia ();
   bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) ib ();
   bin2bcd_seq_if #(.BIN_W(13), .DIGITS(3)) ic ();

   bin2bcd_seq #(.BIN_W(13), .DIGITS(4), .SIGNED_MODE(0)) dut_a (.clk(clk), .reset(rst), .bus(ia));
   bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED_MODE(1)) dut_b (.clk(clk), .reset(rst), .bus(ib));
   bin2bcd_seq #(.BIN_W(13), .DIGITS(3), .SIGNED_MODE(0)) dut_c (.clk(clk), .reset(rst), .bus(ic));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return ia.done;
         1:       return ib.done;
         default: return ic.done;
      endcase
   endfunction

   // Pulse start for one cycle, return edges from the accepting edge to the visible done
   task automatic conv(input int sel, input logic [12:0] v, output int lat);
      case (sel)
         0:       begin ia.bin_in = v;      ia.start = 1'b1; end
         1:       begin ib.bin_in = v[7:0]; ib.start = 1'b1; end
         default: begin ic.bin_in = v;      ic.start = 1'b1; end
      endcase
      @(posedge clk); #1;
      ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done_of(sel)) begin
            lat = n;
            break;
         end
      end
      chk("done_seen", 32'(lat > 0), 32'd1);
   endtask

   int lat, lat2, dones;
   logic [15:0] cap;

   initial begin
      ia.start = 1'b0; ia.bin_in = '0;
      ib.start = 1'b0; ib.bin_in = '0;
      ic.start = 1'b0; ic.bin_in = '0;
      rst = 1'b1;
      #12;
      chk("rst_busy",  32'(ia.busy),       32'd0);
      chk("rst_done",  32'(ia.done),       32'd0);
      chk("rst_bcd",   32'(ia.bcd_out),    32'h0);
      chk("rst_blank", 32'(ia.blank_mask), 32'b1110);
      chk("rst_blankb",32'(ib.blank_mask), 32'b110);
      chk("rst_ovf",   32'(ia.overflow),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Unsigned, full-scale value
      conv(0, 13'd8191, lat);
      chk("a8191_lat",   32'(lat),           32'd14);
      chk("a8191_bcd",   32'(ia.bcd_out),    32'h8191);
      chk("a8191_ovf",   32'(ia.overflow),   32'd0);
      chk("a8191_blank", 32'(ia.blank_mask), 32'b0000);
      chk("a8191_busy",  32'(ia.busy),       32'd0);
      @(posedge clk); #1;
      chk("a8191_pulse", 32'(ia.done),       32'd0);
      chk("a8191_hold",  32'(ia.bcd_out),    32'h8191);

      conv(0, 13'd0, lat);
      chk("a0_bcd",   32'(ia.bcd_out),    32'h0000);
      chk("a0_blank", 32'(ia.blank_mask), 32'b1110);
      conv(0, 13'd42, lat);
      chk("a42_bcd",   32'(ia.bcd_out),    32'h0042);
      chk("a42_blank", 32'(ia.blank_mask), 32'b1100);

      // Signed 8-bit: most negative, most positive, small negative
      conv(1, 13'h080, lat);
      chk("bmin_lat",   32'(lat),           32'd9);
      chk("bmin_bcd",   32'(ib.bcd_out),    32'h128);
      chk("bmin_neg",   32'(ib.neg),        32'd1);
      chk("bmin_blank", 32'(ib.blank_mask), 32'b000);
      conv(1, 13'h07F, lat);
      chk("bmax_bcd", 32'(ib.bcd_out), 32'h127);
      chk("bmax_neg", 32'(ib.neg),     32'd0);
      conv(1, 13'h0FB, lat);
      chk("bm5_bcd",   32'(ib.bcd_out),    32'h005);
      chk("bm5_neg",   32'(ib.neg),        32'd1);
      chk("bm5_blank", 32'(ib.blank_mask), 32'b110);

      // Three digits: saturation, then the largest value that fits
      conv(2, 13'd1000, lat);
      chk("c1000_ovf",   32'(ic.overflow),   32'd1);
      chk("c1000_bcd",   32'(ic.bcd_out),    32'h999);
      chk("c1000_blank", 32'(ic.blank_mask), 32'b000);
      conv(2, 13'd999, lat);
      chk("c999_lat", 32'(lat),         32'd14);
      chk("c999_ovf", 32'(ic.overflow), 32'd0);
      chk("c999_bcd", 32'(ic.bcd_out),  32'h999);

      // Input change and a second start while busy are ignored
      ia.bin_in = 13'd1234; ia.start = 1'b1;
      @(posedge clk); #1;
      ia.start = 1'b0; ia.bin_in = 13'd4321;
      dones = 0; lat = -1; cap = '0;
      for (int n = 1; n <= 20; n++) begin
         ia.start = (n == 3);
         @(posedge clk); #1;
         if (ia.done) begin
            dones++;
            lat = n;
            cap = ia.bcd_out;
         end
      end
      ia.start = 1'b0;
      chk("busy_dones", 32'(dones), 32'd1);
      chk("busy_lat",   32'(lat),   32'd14);
      chk("busy_bcd",   32'(cap),   32'h1234);

      // Start held high: re-accepted in the DONE cycle, back-to-back results
      ia.bin_in = 13'd555; ia.start = 1'b1;
      @(posedge clk); #1;
      ia.bin_in = 13'd7;
      lat = -1; cap = '0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (ia.done) begin lat = n; cap = ia.bcd_out; break; end
      end
      ia.start = 1'b0;
      lat2 = -1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (ia.done) begin lat2 = n; break; end
      end
      chk("b2b_lat1",  32'(lat),           32'd14);
      chk("b2b_bcd1",  32'(cap),           32'h0555);
      chk("b2b_lat2",  32'(lat2),          32'd14);
      chk("b2b_bcd2",  32'(ia.bcd_out),    32'h0007);
      chk("b2b_blank", 32'(ia.blank_mask), 32'b1110);

      // Reset in the middle of a conversion
      ia.bin_in = 13'd999; ia.start = 1'b1;
      @(posedge clk); #1;
      ia.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mrst_busy",  32'(ia.busy),       32'd0);
      chk("mrst_bcd",   32'(ia.bcd_out),    32'h0);
      chk("mrst_blank", 32'(ia.blank_mask), 32'b1110);
      #3 rst = 1'b0;
      dones = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (ia.done) dones++;
      end
      chk("mrst_nodone", 32'(dones), 32'd0);
      conv(0, 13'd100, lat);
      chk("after_lat",   32'(lat),           32'd14);
      chk("after_bcd",   32'(ia.bcd_out),    32'h0100);
      chk("after_blank", 32'(ia.blank_mask), 32'b1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
